// File: rtl/pcileech_cfg_cmd_initiator_pkg.sv
// Shared definitions for the config shadow-register command interface.
// Both the requester (initiator) and the responder import this package so
// the command-word layout and status encoding stay in one place.
package pcileech_cfgcmd_pkg;

    // Initiator sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } cfgcmd_state_e;

    // Completion status codes.
    typedef enum logic [1:0] {
        CFGCMD_OK       = 2'd0,
        CFGCMD_TIMEOUT  = 2'd1,
        CFGCMD_MISMATCH = 2'd2,
        CFGCMD_BAD_FUNC = 2'd3
    } cfgcmd_status_e;

    // Command-word field positions.
    localparam int FUNC_LSB  = 8;
    localparam int SPACE_BIT = 11;
    localparam int WR_BIT    = 12;
    localparam int RD_BIT    = 13;
    localparam int OFS_LSB   = 16;
    localparam int MASK_LSB  = 32;
    localparam int WDATA_LSB = 48;

    // Captured request. mask/wdata are already zero for reads, and the read
    // flag is stored explicitly so an all-zero capture packs to an all-zero word.
    typedef struct packed {
        logic [2:0]  func;
        logic        space;
        logic        write;
        logic        read;
        logic [15:0] offset;
        logic [15:0] mask;
        logic [15:0] wdata;
    } cfgcmd_req_t;

    // Place the captured request fields into the 64-bit command word.
    function automatic logic [63:0] cfgcmd_pack(input cfgcmd_req_t r);
        logic [63:0] w;
        w                    = '0;
        w[FUNC_LSB +: 3]     = r.func;
        w[SPACE_BIT]         = r.space;
        w[WR_BIT]            = r.write;
        w[RD_BIT]            = r.read;
        w[OFS_LSB +: 16]     = r.offset;
        w[MASK_LSB +: 16]    = r.mask;
        w[WDATA_LSB +: 16]   = r.wdata;
        return w;
    endfunction

endpackage

// File: rtl/pcileech_cfg_cmd_initiator.sv
// Requester side of the config shadow-register command interface.
// Takes one read/write request at a time, issues a 64-bit command word,
// waits for the 32-bit echoed response (or a timeout) and returns a
// completion with status. Responses arriving outside WAIT_RSP are counted
// as strays in a saturating counter.
module pcileech_cfg_cmd_initiator
    import pcileech_cfgcmd_pkg::*;
#(
    parameter int unsigned NUM_FUNCTIONS  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned STRAY_W        = 8
) (
    input  logic               clk_pcie,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic               req_rw_space,
    input  logic [2:0]         req_func,
    input  logic [15:0]        req_offset,
    input  logic [15:0]        req_mask,
    input  logic [15:0]        req_wdata,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [63:0]        cmd_data,
    input  logic               rsp_valid,
    input  logic [31:0]        rsp_data,
    output logic               cpl_valid,
    input  logic               cpl_ready,
    output logic [15:0]        cpl_rdata,
    output logic [1:0]         cpl_status,
    output logic               busy,
    output logic [STRAY_W-1:0] stray_count
);

    cfgcmd_state_e  r_state;
    cfgcmd_req_t    r_req;
    logic [15:0]    r_timer;
    logic           r_cmd_valid;
    logic           r_cpl_valid;
    logic [15:0]    r_cpl_rdata;
    cfgcmd_status_e r_cpl_status;
    logic [STRAY_W-1:0] r_stray;

    cfgcmd_req_t    w_req_in;
    logic           w_func_ok;
    logic [15:0]    w_timer_next;
    logic           w_timeout;
    logic           w_ofs_match;

    assign w_func_ok    = (32'(req_func) < NUM_FUNCTIONS);
    assign w_timer_next = r_timer + 16'd1;
    // The window closes when the incremented timer reaches TIMEOUT_CYCLES-1,
    // which places a timeout completion TIMEOUT_CYCLES cycles after the
    // command handshake (the same slot a response on the last cycle gets).
    assign w_timeout    = (32'(w_timer_next) == TIMEOUT_CYCLES - 32'd1);
    assign w_ofs_match  = (rsp_data[31:16] == r_req.offset);

    // Format incoming request fields for capture; reads carry no mask/data.
    always_comb begin
        // NOTE: every field gets a value before any condition, so no latch is inferred.
        w_req_in        = '0;
        w_req_in.func   = req_func;
        w_req_in.space  = req_rw_space;
        w_req_in.write  = req_write;
        w_req_in.read   = ~req_write;
        w_req_in.offset = req_offset;
        if (req_write) begin
            w_req_in.mask  = req_mask;
            w_req_in.wdata = req_wdata;
        end
    end

    // Request sequencing: capture, issue, wait for response/timeout, complete.
    always_ff @(posedge clk_pcie) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_timer      <= '0;
            r_cmd_valid  <= 1'b0;
            r_cpl_valid  <= 1'b0;
            r_cpl_rdata  <= '0;
            r_cpl_status <= CFGCMD_OK;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req <= w_req_in;
                        if (w_func_ok) begin
                            r_state     <= ST_ISSUE;
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_state      <= ST_DONE;
                            r_cpl_valid  <= 1'b1;
                            r_cpl_status <= CFGCMD_BAD_FUNC;
                            r_cpl_rdata  <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_state     <= ST_WAIT_RSP;
                        r_cmd_valid <= 1'b0;
                        r_timer     <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    r_timer <= w_timer_next;
                    // A response on the expiry cycle takes priority over the timeout.
                    if (rsp_valid) begin
                        r_state     <= ST_DONE;
                        r_cpl_valid <= 1'b1;
                        if (w_ofs_match) begin
                            r_cpl_status <= CFGCMD_OK;
                            r_cpl_rdata  <= r_req.write ? 16'h0000
                                                        : {rsp_data[7:0], rsp_data[15:8]};
                        end else begin
                            r_cpl_status <= CFGCMD_MISMATCH;
                            r_cpl_rdata  <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_DONE;
                        r_cpl_valid  <= 1'b1;
                        r_cpl_status <= CFGCMD_TIMEOUT;
                        r_cpl_rdata  <= '0;
                    end
                end
                ST_DONE: begin
                    if (cpl_ready) begin
                        r_state     <= ST_IDLE;
                        r_cpl_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Count responses that arrive while no response is expected; saturate.
    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            r_stray <= '0;
        end else if (rsp_valid && (r_state != ST_WAIT_RSP) && !(&r_stray)) begin
            r_stray <= r_stray + STRAY_W'(1);
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign cmd_valid   = r_cmd_valid;
    assign cmd_data    = cfgcmd_pack(r_req);
    assign cpl_valid   = r_cpl_valid;
    assign cpl_rdata   = r_cpl_rdata;
    assign cpl_status  = r_cpl_status;
    assign stray_count = r_stray;

endmodule

// File: tb/tb_pcileech_cfg_cmd_initiator.sv
// Self-checking bench for pcileech_cfg_cmd_initiator: directed vector table,
// randomized transactions against a transaction-level model, and hand-written
// sequences for timeout, back-pressure, reset and stray saturation.
`timescale 1ns/1ps
module tb_pcileech_cfg_cmd_initiator;

    localparam int T  = 16;
    localparam int SW = 8;

    typedef struct {
        logic [2:0]  func;
        logic        write;
        logic        space;
        logic [15:0] offset;
        logic [15:0] mask;
        logic [15:0] wdata;
        int          rdy_dly;
        int          rsp_dly;   // 0 = never respond
        logic [31:0] rsp_word;
        int          cpl_hold;
    } txn_t;

    typedef struct {
        logic [63:0] cmd;
        bit          issued;
        bit          cmd_stable;
        bit          cmd_dropped;
        logic [1:0]  status;
        logic [15:0] rdata;
        int          lat;
        bit          cpl_stable;
    } res_t;

    typedef struct {
        txn_t        t;
        logic [63:0] cmd;
        bit          issued;
        logic [1:0]  st;
        logic [15:0] rd;
        int          lat;
    } vec_t;

    logic        clk_pcie = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_rw_space = 1'b0;
    logic [2:0]  req_func = '0;
    logic [15:0] req_offset = '0, req_mask = '0, req_wdata = '0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, cpl_ready = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        req_ready, cmd_valid, cpl_valid, busy;
    logic [63:0] cmd_data;
    logic [15:0] cpl_rdata;
    logic [1:0]  cpl_status;
    logic [SW-1:0] stray_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_stray = 0;

    pcileech_cfg_cmd_initiator #(
        .NUM_FUNCTIONS (2),
        .TIMEOUT_CYCLES(T),
        .STRAY_W       (SW)
    ) dut (
        .clk_pcie    (clk_pcie),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_rw_space(req_rw_space),
        .req_func    (req_func),
        .req_offset  (req_offset),
        .req_mask    (req_mask),
        .req_wdata   (req_wdata),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .cpl_valid   (cpl_valid),
        .cpl_ready   (cpl_ready),
        .cpl_rdata   (cpl_rdata),
        .cpl_status  (cpl_status),
        .busy        (busy),
        .stray_count (stray_count)
    );

    always #5 clk_pcie = ~clk_pcie;
    always @(posedge clk_pcie) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pcie);
        #1;
    endtask

    // Response pulse while the DUT is not waiting for one.
    task automatic stray_pulse(input logic [15:0] ofs);
        rsp_valid = 1'b1;
        rsp_data  = {ofs, 16'h0000};
        step();
        rsp_valid = 1'b0;
        if (model_stray < 255) model_stray++;
    endtask

    // Transaction-level expectation from the interface rules.
    function automatic void model(input txn_t t, output logic [63:0] cmd, output bit issued,
                                  output logic [1:0] st, output logic [15:0] rd, output int lat);
        cmd = 64'h0;
        rd  = 16'h0;
        issued = (t.func < 3'd2);
        if (!issued) begin
            st  = 2'd3;
            lat = 1;
            return;
        end
        cmd = (64'(t.func) << 8) | (64'(t.space) << 11) | (64'(t.offset) << 16);
        if (t.write) cmd = cmd | (64'd1 << 12) | (64'(t.mask) << 32) | (64'(t.wdata) << 48);
        else         cmd = cmd | (64'd1 << 13);
        if (t.rsp_dly >= 1 && t.rsp_dly <= T - 1) begin
            lat = t.rsp_dly + 1;
            if (t.rsp_word[31:16] == t.offset) begin
                st = 2'd0;
                if (!t.write) rd = {t.rsp_word[7:0], t.rsp_word[15:8]};
            end else begin
                st = 2'd2;
            end
        end else begin
            st  = 2'd1;
            lat = T;
        end
    endfunction

    // Drive one request through accept, command handshake, response and completion.
    task automatic run_txn(input txn_t t, output res_t r);
        int h;
        int n;
        r.cmd = '0; r.issued = 0; r.cmd_stable = 0; r.cmd_dropped = 0;
        r.status = '0; r.rdata = '0; r.lat = -1; r.cpl_stable = 0;
        req_valid = 1'b1; req_func = t.func; req_write = t.write; req_rw_space = t.space;
        req_offset = t.offset; req_mask = t.mask; req_wdata = t.wdata;
        h = cyc;
        step();
        req_valid = 1'b0;
        req_offset = 16'($urandom); req_mask = 16'($urandom); req_wdata = 16'($urandom);
        if (cmd_valid === 1'b1) begin
            r.issued = 1;
            r.cmd = cmd_data;
            r.cmd_stable = 1;
            for (int i = 0; i < t.rdy_dly; i++) begin
                step();
                if (cmd_valid !== 1'b1 || cmd_data !== r.cmd) r.cmd_stable = 0;
            end
            cmd_ready = 1'b1;
            h = cyc;
            step();
            cmd_ready = 1'b0;
            r.cmd_dropped = (cmd_valid === 1'b0);
            if (t.rsp_dly > 0) begin
                for (int i = 1; i < t.rsp_dly; i++) step();
                rsp_valid = 1'b1;
                rsp_data  = t.rsp_word;
                step();
                rsp_valid = 1'b0;
            end
        end
        n = 0;
        while (cpl_valid !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (cpl_valid === 1'b1) begin
            r.lat = cyc - h;
            r.status = cpl_status;
            r.rdata = cpl_rdata;
            r.cpl_stable = 1;
            for (int i = 0; i < t.cpl_hold; i++) begin
                step();
                if (cpl_valid !== 1'b1 || cpl_status !== r.status || cpl_rdata !== r.rdata ||
                    req_ready !== 1'b0 || busy !== 1'b1) r.cpl_stable = 0;
            end
            cpl_ready = 1'b1;
            step();
            cpl_ready = 1'b0;
        end
    endtask

    function automatic vec_t mk(input logic [2:0] func, input logic write, input logic space,
                                input logic [15:0] ofs, input logic [15:0] mask, input logic [15:0] wdata,
                                input int rdy, input int rsp, input logic [31:0] word, input int hold,
                                input logic [63:0] cmd, input bit issued, input logic [1:0] st,
                                input logic [15:0] rd, input int lat);
        vec_t v;
        v.t.func = func; v.t.write = write; v.t.space = space; v.t.offset = ofs;
        v.t.mask = mask; v.t.wdata = wdata; v.t.rdy_dly = rdy; v.t.rsp_dly = rsp;
        v.t.rsp_word = word; v.t.cpl_hold = hold;
        v.cmd = cmd; v.issued = issued; v.st = st; v.rd = rd; v.lat = lat;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_stray"}, 64'(stray_count), 64'(model_stray));
    endtask

    initial begin
        vec_t vecs[9];
        res_t r;
        txn_t t;
        logic [63:0] e_cmd;
        bit          e_iss;
        logic [1:0]  e_st;
        logic [15:0] e_rd;
        int          e_lat;
        bit          seen;

        vecs[0] = mk(3'd1, 1'b0, 1'b0, 16'h0040, 16'hFFFF, 16'h1111, 0, 3, 32'h0040_3412, 0,
                     64'h0000_0000_0040_2100, 1, 2'd0, 16'h1234, 4);
        vecs[1] = mk(3'd0, 1'b1, 1'b1, 16'h0010, 16'h00FF, 16'hABCD, 4, 2, 32'h0010_CDAB, 0,
                     64'hABCD_00FF_0010_1800, 1, 2'd0, 16'h0000, 3);
        vecs[2] = mk(3'd1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 0, 2, 32'h0042_3412, 0,
                     64'h0000_0000_0040_2100, 1, 2'd2, 16'h0000, 3);
        vecs[3] = mk(3'd2, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 32'h0, 0,
                     64'h0, 0, 2'd3, 16'h0000, 1);
        vecs[4] = mk(3'd7, 1'b1, 1'b1, 16'h0100, 16'hFFFF, 16'h5A5A, 0, 0, 32'h0, 0,
                     64'h0, 0, 2'd3, 16'h0000, 1);
        vecs[5] = mk(3'd0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 0, 0, 32'h0, 0,
                     64'h0000_0000_1234_2800, 1, 2'd1, 16'h0000, 16);
        vecs[6] = mk(3'd1, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 2, 15, 32'hBEEF_A55A, 0,
                     64'h0000_0000_BEEF_2900, 1, 2'd0, 16'h5AA5, 16);
        vecs[7] = mk(3'd1, 1'b1, 1'b0, 16'hFFFE, 16'h8001, 16'h0F0F, 1, 1, 32'hFFFE_0000, 10,
                     64'h0F0F_8001_FFFE_1100, 1, 2'd0, 16'h0000, 2);
        vecs[8] = mk(3'd0, 1'b1, 1'b1, 16'h0002, 16'hFFFF, 16'h1234, 0, 5, 32'h0003_0000, 0,
                     64'h1234_FFFF_0002_1800, 1, 2'd2, 16'h0000, 6);

        // Reset, then check the first cycle after deassertion.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        check("rst_cpl_rdata", 64'(cpl_rdata), 64'd0);
        check("rst_cpl_status", 64'(cpl_status), 64'd0);
        check_idle("rst");

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].t, r);
            check($sformatf("vec%0d_issued", i), 64'(r.issued), 64'(vecs[i].issued));
            if (vecs[i].issued) begin
                check($sformatf("vec%0d_cmd", i), r.cmd, vecs[i].cmd);
                check($sformatf("vec%0d_cmd_stable", i), 64'(r.cmd_stable), 64'd1);
                check($sformatf("vec%0d_cmd_drop", i), 64'(r.cmd_dropped), 64'd1);
            end
            check($sformatf("vec%0d_status", i), 64'(r.status), 64'(vecs[i].st));
            check($sformatf("vec%0d_rdata", i), 64'(r.rdata), 64'(vecs[i].rd));
            check($sformatf("vec%0d_lat", i), 64'(r.lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_cpl_stable", i), 64'(r.cpl_stable), 64'd1);
            check_idle($sformatf("vec%0d_post", i));
        end

        // Timeout followed by a late response five cycles later: stray, no completion.
        run_txn(vecs[5].t, r);
        check("to_status", 64'(r.status), 64'd1);
        check("to_lat", 64'(r.lat), 64'(T));
        repeat (4) step();
        stray_pulse(16'h1234);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpl_valid !== 1'b0) seen = 1;
            step();
        end
        check("late_no_cpl", 64'(seen), 64'd0);
        check_idle("late");

        // Randomized transactions against the model, with idle strays in between.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) != 0) t.func = 3'($urandom_range(0, 1));
            else                           t.func = 3'($urandom_range(2, 7));
            t.write = 1'($urandom); t.space = 1'($urandom);
            t.offset = 16'($urandom); t.mask = 16'($urandom); t.wdata = 16'($urandom);
            t.rdy_dly = $urandom_range(0, 3);
            t.rsp_dly = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, T - 1);
            t.rsp_word = {t.offset, 16'($urandom)};
            if ($urandom_range(0, 4) == 0) t.rsp_word[31:16] = t.offset ^ (16'd1 << $urandom_range(0, 15));
            t.cpl_hold = $urandom_range(0, 2);
            model(t, e_cmd, e_iss, e_st, e_rd, e_lat);
            run_txn(t, r);
            check($sformatf("rnd%0d_issued", k), 64'(r.issued), 64'(e_iss));
            if (e_iss) check($sformatf("rnd%0d_cmd", k), r.cmd, e_cmd);
            check($sformatf("rnd%0d_status", k), 64'(r.status), 64'(e_st));
            check($sformatf("rnd%0d_rdata", k), 64'(r.rdata), 64'(e_rd));
            check($sformatf("rnd%0d_lat", k), 64'(r.lat), 64'(e_lat));
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) stray_pulse(16'($urandom));
            check($sformatf("rnd%0d_stray", k), 64'(stray_count), 64'(model_stray));
        end

        // Reset while waiting for a response; the response that follows is stray.
        req_valid = 1'b1; req_func = 3'd1; req_write = 1'b0; req_rw_space = 1'b0; req_offset = 16'h0040;
        step();
        req_valid = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        step();
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        model_stray = 0;
        check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("mid_rst_cpl_valid", 64'(cpl_valid), 64'd0);
        check("mid_rst_cpl_rdata", 64'(cpl_rdata), 64'd0);
        check("mid_rst_cpl_status", 64'(cpl_status), 64'd0);
        check_idle("mid_rst");
        rst = 1'b0;
        step();
        stray_pulse(16'h0040);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (cpl_valid !== 1'b0) seen = 1;
            step();
        end
        check("mid_no_cpl", 64'(seen), 64'd0);
        check_idle("mid_post");

        // Stray counter saturation.
        for (int i = 0; i < 300; i++) stray_pulse(16'($urandom));
        step();
        check("stray_sat", 64'(stray_count), 64'd255);
        check("stray_sat_model", 64'(stray_count), 64'(model_stray));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
